// File: rtl/cpu_defs.sv
// Definitions shared by the fetch stage and the main control decoder:
// opcode constants, the fetch FSM encoding and the default reset PC.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

  // J-type target: the top nibble stays in the current 256 MB region.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump, taken BEQ/BNE, or fall-through.
module next_pc_calc
  import cpu_defs::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] inst_index,
  input  logic [31:0] imm_ext,
  input  logic        branch,
  input  logic        bne,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic branch_taken;

  // BEQ takes on zero, BNE on non-zero; the XOR folds both into one test.
  assign branch_taken = branch & (zero ^ bne);

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target(pc_plus4, inst_index);
    end else if (branch_taken) begin
      next_pc = pc_plus4 + (imm_ext << 2);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: holds the PC, fetches one word over req/ready,
// presents it to the decoder until acknowledged, then advances the PC.
module inst_fetch
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  output logic             inst_valid,
  output logic [31:0]      inst,
  output logic [5:0]       opcode,
  output logic [5:0]       funct,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic             inst_ack,
  input  logic             branch,
  input  logic             bne,
  input  logic             jump,
  input  logic             zero,
  input  logic [31:0]      imm_ext,
  output logic [CNT_W-1:0] retired
);

  fetch_state_t     state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic [31:0]      inst_reg, inst_next;
  logic             valid_reg, valid_next;
  logic [CNT_W-1:0] retired_reg, retired_next;
  logic             req_en_reg;
  logic [31:0]      seq_pc;
  logic [31:0]      target_pc;

  assign seq_pc = pc_reg + 32'd4;

  next_pc_calc u_next_pc (
    .pc_plus4   (seq_pc),
    .inst_index (inst_reg[25:0]),
    .imm_ext    (imm_ext),
    .branch     (branch),
    .bne        (bne),
    .jump       (jump),
    .zero       (zero),
    .next_pc    (target_pc)
  );

  // req_en_reg keeps the request low for one cycle after reset, so a late
  // ready from an aborted fetch cannot be latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= FETCH;
      pc_reg      <= RESET_PC;
      inst_reg    <= 32'h0;
      valid_reg   <= 1'b0;
      retired_reg <= '0;
      req_en_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      inst_reg    <= inst_next;
      valid_reg   <= valid_next;
      retired_reg <= retired_next;
      req_en_reg  <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    inst_next    = inst_reg;
    valid_next   = valid_reg;
    retired_next = retired_reg;
    imem_req     = 1'b0;
    case (state_reg)
      FETCH: begin
        imem_req = req_en_reg;
        if (req_en_reg) begin
          if (imem_ready) begin
            inst_next  = imem_rdata;
            valid_next = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          inst_next  = imem_rdata;
          valid_next = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (inst_ack) begin
          pc_next      = target_pc;
          retired_next = retired_reg + {{(CNT_W-1){1'b0}}, 1'b1};
          valid_next   = 1'b0;
          state_next   = FETCH;
        end
      end
      default: begin
        state_next = FETCH;
        valid_next = 1'b0;
      end
    endcase
  end

  assign imem_addr  = pc_reg;
  assign pc         = pc_reg;
  assign pc_plus4   = seq_pc;
  assign inst       = inst_reg;
  assign opcode     = inst_reg[31:26];
  assign funct      = inst_reg[5:0];
  assign inst_valid = valid_reg;
  assign retired    = retired_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: transaction-level model checked every
// cycle, directed PC scenarios with literal expectations, then random traffic.
module tb_inst_fetch;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        inst_ack;
  logic        branch;
  logic        bne;
  logic        jump;
  logic        zero;
  logic [31:0] imm_ext;
  logic [31:0] retired;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .inst_valid (inst_valid),
    .inst       (inst),
    .opcode     (opcode),
    .funct      (funct),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .inst_ack   (inst_ack),
    .branch     (branch),
    .bne        (bne),
    .jump       (jump),
    .zero       (zero),
    .imm_ext    (imm_ext),
    .retired    (retired)
  );

  int n_vec = 0;
  int n_err = 0;

  // Instruction memory: a few fixed words for the directed walk, hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h0800_0040;
      32'h0000_0100: return 32'h10A5_FFFE;
      32'h0000_0104: return 32'h0800_0040;
      32'h0000_0110: return 32'h0800_0040;
      32'h1000_0040: return 32'h0800_0010;
      default:       return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endcase
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] iw,
                                           input logic br, input logic bn, input logic j,
                                           input logic z, input logic [31:0] imm);
    logic [31:0] seq;
    seq = p + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) * 32'd4);
    if (br && (z != bn)) return seq + imm * 32'd4;
    return seq;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always_comb imem_rdata = mem_word(imem_addr);

  // Behavioural model: fetch phase (armed/requesting/holding), expected PC and count.
  logic        m_live = 1'b0;
  logic        m_armed = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_inst = 32'h0;
  logic [31:0] m_retired = 32'h0;

  always @(negedge clk) begin
    logic [31:0] nx;
    if (m_live) begin
      check32("imem_req", {31'b0, imem_req}, {31'b0, m_armed && !m_valid});
      check32("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
      check32("pc", pc, m_pc);
      check32("pc_plus4", pc_plus4, m_pc + 32'd4);
      check32("retired", retired, m_retired);
      if (m_armed && !m_valid) check32("imem_addr", imem_addr, m_pc);
      if (m_valid) begin
        check32("inst", inst, m_inst);
        check32("opcode", {26'b0, opcode}, m_inst >> 26);
        check32("funct", {26'b0, funct}, m_inst & 32'h3F);
      end
    end
    if (rst) begin
      m_live    = 1'b1;
      m_armed   = 1'b0;
      m_valid   = 1'b0;
      m_pc      = 32'h0;
      m_inst    = 32'h0;
      m_retired = 32'h0;
    end else if (m_live) begin
      if (!m_armed) begin
        m_armed = 1'b1;
      end else if (!m_valid) begin
        if (imem_ready) begin
          m_inst  = mem_word(m_pc);
          m_valid = 1'b1;
        end
      end else if (inst_ack) begin
        nx = ref_next(m_pc, m_inst, branch, bne, jump, zero, imm_ext);
        m_retired = m_retired + 32'd1;
        $display("retire %0d: pc=%h inst=%h br=%b bne=%b j=%b z=%b imm=%h -> %h",
                 m_retired, m_pc, m_inst, branch, bne, jump, zero, imm_ext, nx);
        m_pc    = nx;
        m_valid = 1'b0;
      end
    end
  end

  logic [31:0] addr_q[$];
  logic        cap_en = 1'b0;
  always @(negedge clk) if (cap_en && imem_req) addr_q.push_back(imem_addr);

  task automatic do_instr(input logic br, input logic bn, input logic j, input logic z,
                          input logic [31:0] imm, input logic [31:0] exp_pc, input string name);
    for (int k = 0; k < 20 && !inst_valid; k++) begin
      @(posedge clk); #1;
    end
    if (!inst_valid) begin
      check32({name, "_timeout"}, {31'b0, inst_valid}, 32'h1);
    end else begin
      branch = br; bne = bn; jump = j; zero = z; imm_ext = imm; inst_ack = 1'b1;
      @(posedge clk); #1;
      inst_ack = 1'b0; branch = 1'b0; bne = 1'b0; jump = 1'b0; zero = 1'b0; imm_ext = 32'h0;
      check32(name, pc, exp_pc);
    end
  endtask

  initial begin
    int stable_cnt;
    logic [31:0] r;
    rst = 1'b1; imem_ready = 1'b0; inst_ack = 1'b0;
    branch = 1'b0; bne = 1'b0; jump = 1'b0; zero = 1'b0; imm_ext = 32'h0;

    // Model pins against hand-computed next-PC values.
    check32("pin_beq_taken", ref_next(32'h100, 32'h0, 1, 0, 0, 1, 32'hFFFF_FFFE), 32'h0FC);
    check32("pin_bne_taken", ref_next(32'h100, 32'h0, 1, 1, 0, 0, 32'h3), 32'h110);
    check32("pin_jump_prio", ref_next(32'h1000_0040, 32'h10, 1, 0, 1, 1, 32'h7), 32'h1000_0040);
    check32("pin_wrap", ref_next(32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 32'h0), 32'h0);

    repeat (2) @(posedge clk);
    #1;
    check32("rst_req", {31'b0, imem_req}, 32'h0);
    check32("rst_valid", {31'b0, inst_valid}, 32'h0);
    check32("rst_retired", retired, 32'h0);
    check32("rst_pc", pc, 32'h0);
    check32("rst_inst", inst, 32'h0);

    // Zero-wait memory, ack every ISSUE: two cycles per instruction.
    rst = 1'b0; imem_ready = 1'b1; inst_ack = 1'b1; cap_en = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    cap_en = 1'b0;
    check32("seq_len", addr_q.size(), 32'd4);
    if (addr_q.size() >= 4) begin
      check32("seq_a0", addr_q[0], 32'h0);
      check32("seq_a1", addr_q[1], 32'h4);
      check32("seq_a2", addr_q[2], 32'h8);
      check32("seq_a3", addr_q[3], 32'hC);
    end
    check32("seq_retired", retired, 32'd4);

    // Ready delayed three cycles: request and address hold for four cycles.
    imem_ready = 1'b0; inst_ack = 1'b0;
    stable_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h10) stable_cnt++;
      @(posedge clk); #1;
    end
    check32("wait_no_valid", {31'b0, inst_valid}, 32'h0);
    imem_ready = 1'b1;
    @(negedge clk);
    if (imem_req && imem_addr == 32'h10) stable_cnt++;
    @(posedge clk); #1;
    check32("wait_hold_cycles", stable_cnt, 32'd4);
    check32("wait_valid", {31'b0, inst_valid}, 32'h1);
    check32("wait_inst", inst, 32'h0800_0040);
    check32("wait_opcode", {26'b0, opcode}, 32'h02);

    // Directed PC walk: jumps, BEQ/BNE taken and not, jump priority, wrap.
    do_instr(0, 0, 1, 0, 32'h0,          32'h0000_0100, "j_to_100");
    do_instr(1, 0, 0, 1, 32'hFFFF_FFFE,  32'h0000_00FC, "beq_taken");
    do_instr(0, 0, 0, 0, 32'h0,          32'h0000_0100, "seq_to_100");
    do_instr(1, 0, 0, 0, 32'hFFFF_FFFE,  32'h0000_0104, "beq_not");
    do_instr(0, 0, 1, 0, 32'h0,          32'h0000_0100, "j_back1");
    do_instr(1, 1, 0, 0, 32'h3,          32'h0000_0110, "bne_taken");
    do_instr(0, 0, 1, 0, 32'h0,          32'h0000_0100, "j_back2");
    do_instr(1, 1, 0, 1, 32'h3,          32'h0000_0104, "bne_not");
    do_instr(1, 0, 0, 1, 32'h03FF_FFCE,  32'h1000_0040, "br_far");
    do_instr(1, 0, 1, 1, 32'h0,          32'h1000_0040, "jump_prio");
    do_instr(1, 0, 0, 1, 32'h3BFF_FFEE,  32'hFFFF_FFFC, "br_top");
    do_instr(0, 0, 0, 0, 32'h0,          32'h0000_0000, "pc_wrap");
    do_instr(0, 0, 0, 0, 32'h0,          32'h0000_0004, "seq_to_4");

    // Reset while waiting, with a ready pulse right after: data is discarded.
    imem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; imem_ready = 1'b1;
    check32("mid_rst_req", {31'b0, imem_req}, 32'h0);
    check32("mid_rst_pc", pc, 32'h0);
    check32("mid_rst_retired", retired, 32'h0);
    check32("mid_rst_valid", {31'b0, inst_valid}, 32'h0);
    @(posedge clk); #1;
    imem_ready = 1'b0;
    check32("mid_rst_discard", {31'b0, inst_valid}, 32'h0);
    check32("mid_rst_rereq", {31'b0, imem_req}, 32'h1);
    check32("mid_rst_addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    @(posedge clk); #1;
    check32("mid_rst_refetch", {31'b0, inst_valid}, 32'h1);
    check32("mid_rst_inst", inst, mem_word(32'h0));

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      r = $urandom;
      rst        = ($urandom_range(0, 249) == 0);
      imem_ready = ($urandom_range(0, 2) != 0);
      inst_ack   = r[0];
      branch     = (r[2:1] == 2'b00);
      bne        = r[3];
      jump       = (r[6:4] == 3'b000);
      zero       = r[7];
      imm_ext    = {{26{r[13]}}, r[13:8]};
    end
    @(posedge clk); #1;
    rst = 1'b0; inst_ack = 1'b0; imem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
